sha256_id_buffer: RTL and testbench
===================================

Name: sha256_id_buffer

Overview:
- Small synchronous FIFO in the SHA-256 accelerator. It holds the packet ID (plus the last-of-packet flag) for each block entering the hash pipeline.
- IDs are returned in order, one per hash result.
- Both sides use valid/ready handshakes.
- A status register tracks the ID of the most recent output transfer.

Parameters:
- ID_W, 6, width of id_in/id_out/status_id.
- DEPTH, 4, number of storage entries. Must be a power of 2 and ≥ 2.

Ports:
- clk  in  1  rising-edge clock
- nrst  in  1  asynchronous active-low reset
- en  in  1  block enable; 0 freezes all state and blocks handshakes
- sync_rst  in  1  synchronous clear; takes priority over en
- id_in  in  ID_W  input ID
- id_in_last  in  1  input last-of-packet flag
- id_in_valid  in  1  input valid
- id_in_ready  out  1  input ready
- id_out  out  ID_W  output ID (head entry)
- id_out_last  out  1  output last flag (head entry)
- id_out_valid  out  1  output valid
- id_out_ready  in  1  output ready
- status_id  out  ID_W  ID of the last completed output transfer

Behaviour:
- Reset and clear:
  - nrst low: pointers = 0, count = 0, status_id = 0, so empty.
  - Hence id_out_valid = 0, id_in_ready = 1 (once en = 1), id_out = 0, id_out_last = 0.
  - sync_rst = 1 at a rising edge gives the same clear, regardless of en. Storage contents need not be cleared.
  - Reset mid-operation discards all stored entries. In-flight handshakes in that cycle are ignored.
- Enable gating:
  - id_in_ready = en & ~full.
  - id_out_valid = en & ~empty.
  - With en = 0 no push/pop occurs and all state holds.
- Push: on a rising edge with id_in_valid & id_in_ready, write {id_in, id_in_last} at the write pointer and increment it (wrap modulo DEPTH).
- Pop:
  - On a rising edge with id_out_valid & id_out_ready, advance the read pointer (wrap modulo DEPTH).
  - In the same edge, load status_id with the id_out value being transferred.
  - During the handshake cycle itself, status_id still shows the previous transfer's ID (0 after reset).
- Outputs:
  - id_out/id_out_last reflect the head entry combinationally from storage.
  - Both are forced to 0 when id_out_valid = 0.
- Latency: an entry pushed at edge N is presented with id_out_valid = 1 after edge N. There is no combinational in-to-out bypass.
- Simultaneous push and pop:
  - Allowed whenever both handshakes are valid; count unchanged.
  - When full, id_in_ready = 0 even if a pop occurs in that cycle. Ready depends only on registered state.
- Full/empty tracking:
  - Use a count register of width clog2(DEPTH)+1, or an extra pointer wrap bit.
  - Full is count == DEPTH; empty is count == 0.
- Ordering: strict FIFO. The last flag travels with its ID unchanged.
- Holding: id_out, id_out_last and id_out_valid stay stable while valid & ~ready. id_in is never altered.

Test Plan:
- Reset then single transfer:
  - Push id 5, last 1; output ready held high.
  - id_out = 5, last = 1, valid asserted the cycle after the push.
  - status_id = 0 during the handshake and 5 afterwards.
- Streaming with gaps: push IDs 1,2,3 (last on 3) with random 0–3 cycle input gaps and random 0–3 cycle output stalls → outputs 1,2,3 in order, last only on 3. At each handshake status_id equals the previous ID (0,1,2).
- Fill to full: output ready low, push DEPTH entries 10..13.
  - id_in_ready drops after the 4th push.
  - Then raise ready → 10..13 drain in order; id_in_ready returns after the first pop.
- Simultaneous push/pop with one entry stored and both handshakes active → count stays 1, data order preserved, no loss or duplication.
- Enable and clear:
  - en = 0 with entries stored → valid/ready low, state held; en = 1 resumes with the same head.
  - sync_rst pulse → buffer empty, status_id = 0.
- Pointer wrap: push/pop 3×DEPTH IDs 0..11 continuously → all received in order across pointer wrap-around.

Source files
------------

// File: rtl/sha256_id_buffer.sv
// rtl/sha256_id_buffer.sv - in-order packet ID FIFO for the SHA-256 hash pipeline
//
// Purpose: stores {id, last} for each block entering the hash pipeline and
//          returns them in order, one per hash result.
// Ports:
//   clk, nrst            clock, asynchronous active-low reset
//   en                   block enable (0 freezes state, blocks handshakes)
//   sync_rst             synchronous clear, overrides en
//   id_in/_last/_valid   input side, id_in_ready back-pressure
//   id_out/_last/_valid  output side (head entry), id_out_ready from consumer
//   status_id            ID of the most recent completed output transfer
module sha256_id_buffer #(
    parameter int ID_W  = 6,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            en,
    input  logic            sync_rst,
    input  logic [ID_W-1:0] id_in,
    input  logic            id_in_last,
    input  logic            id_in_valid,
    output logic            id_in_ready,
    output logic [ID_W-1:0] id_out,
    output logic            id_out_last,
    output logic            id_out_valid,
    input  logic            id_out_ready,
    output logic [ID_W-1:0] status_id
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    // Each entry packs the ID above its last-of-packet flag.
    logic [ID_W:0]    r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [ID_W-1:0]  r_status_id;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [ID_W:0]    w_head;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // Ready depends only on registered state: a full buffer refuses input
    // even when a pop happens in the same cycle.
    assign id_in_ready  = en & ~w_full;
    assign id_out_valid = en & ~w_empty;

    assign w_push = id_in_valid & id_in_ready;
    assign w_pop  = id_out_valid & id_out_ready;

    assign w_head      = r_mem[r_rd_ptr];
    assign id_out      = id_out_valid ? w_head[ID_W:1] : '0;
    assign id_out_last = id_out_valid & w_head[0];
    assign status_id   = r_status_id;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_status_id <= '0;
        end else if (sync_rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_status_id <= '0;
        end else begin
            // Both handshakes already include en, so en = 0 holds everything.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + AW'(1);
                r_status_id <= w_head[ID_W:1];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; stale entries are unreachable once count is 0.
    always_ff @(posedge clk) begin
        if (w_push && !sync_rst) begin
            r_mem[r_wr_ptr] <= {id_in, id_in_last};
        end
    end

endmodule

// File: tb/tb_sha256_id_buffer.sv
// tb/tb_sha256_id_buffer.sv - self-checking bench for sha256_id_buffer
module tb_sha256_id_buffer;

    localparam int ID_W  = 6;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            nrst;
    logic            en;
    logic            sync_rst;
    logic [ID_W-1:0] id_in;
    logic            id_in_last;
    logic            id_in_valid;
    logic            id_in_ready;
    logic [ID_W-1:0] id_out;
    logic            id_out_last;
    logic            id_out_valid;
    logic            id_out_ready;
    logic [ID_W-1:0] status_id;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a queue of {id, last} plus the last transferred ID.
    logic [ID_W:0]   m_q[$];
    logic [ID_W-1:0] m_status;

    typedef struct {
        logic            en, srst, iv;
        logic [ID_W-1:0] id;
        logic            last, ordy;
        logic            ev, er;
        logic [ID_W-1:0] eid;
        logic            elast;
        logic [ID_W-1:0] est;
    } vec_t;

    vec_t vecs[$];

    sha256_id_buffer #(.ID_W(ID_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .en           (en),
        .sync_rst     (sync_rst),
        .id_in        (id_in),
        .id_in_last   (id_in_last),
        .id_in_valid  (id_in_valid),
        .id_in_ready  (id_in_ready),
        .id_out       (id_out),
        .id_out_last  (id_out_last),
        .id_out_valid (id_out_valid),
        .id_out_ready (id_out_ready),
        .status_id    (status_id)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(int e, int s, int v, int d, int l, int r,
                                int ev, int er, int eid, int el, int est);
        vec_t t;
        t.en = 1'(e); t.srst = 1'(s); t.iv = 1'(v); t.id = ID_W'(d);
        t.last = 1'(l); t.ordy = 1'(r); t.ev = 1'(ev); t.er = 1'(er);
        t.eid = ID_W'(eid); t.elast = 1'(el); t.est = ID_W'(est);
        return t;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic ev, input logic er,
                              input logic [ID_W-1:0] eid, input logic el,
                              input logic [ID_W-1:0] est);
        chk({tag, " valid"},  int'(id_out_valid), int'(ev));
        chk({tag, " ready"},  int'(id_in_ready),  int'(er));
        chk({tag, " id_out"}, int'(id_out),       int'(eid));
        chk({tag, " last"},   int'(id_out_last),  int'(el));
        chk({tag, " status"}, int'(status_id),    int'(est));
    endtask

    task automatic model_check(input string tag);
        logic ev, er;
        logic [ID_W-1:0] eid;
        logic el;
        ev  = en && (m_q.size() != 0);
        er  = en && (m_q.size() < DEPTH);
        eid = ev ? m_q[0][ID_W:1] : '0;
        el  = ev ? m_q[0][0] : 1'b0;
        check_outs(tag, ev, er, eid, el, m_status);
    endtask

    task automatic apply(input logic e, input logic s, input logic v,
                         input logic [ID_W-1:0] d, input logic l, input logic r);
        en = e; sync_rst = s; id_in_valid = v; id_in = d;
        id_in_last = l; id_out_ready = r;
    endtask

    // Advance one edge and let the model see the same handshake inputs.
    task automatic tick();
        bit can_pop, can_push;
        @(posedge clk);
        if (sync_rst) begin
            m_q.delete();
            m_status = '0;
        end else if (en) begin
            can_pop  = (m_q.size() != 0) && id_out_ready;
            can_push = (m_q.size() < DEPTH) && id_in_valid;
            if (can_pop) begin
                m_status = m_q[0][ID_W:1];
                void'(m_q.pop_front());
            end
            if (can_push) m_q.push_back({id_in, id_in_last});
        end
        #1;
    endtask

    task automatic model_cycle(input string tag, input logic e, input logic s,
                               input logic v, input logic [ID_W-1:0] d,
                               input logic l, input logic r);
        apply(e, s, v, d, l, r);
        @(negedge clk);
        model_check(tag);
        tick();
    endtask

    initial begin
        m_status = '0;
        nrst = 1'b0;
        apply(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check_outs("reset", 1'b0, 1'b1, '0, 1'b0, '0);
        @(posedge clk);
        #1 nrst = 1'b1;

        // en srst iv id last ordy | valid ready id last status
        vecs.push_back(mk(1,0,0, 0,0,1, 0,1, 0,0, 0));
        vecs.push_back(mk(1,0,1, 5,1,1, 0,1, 0,0, 0));
        vecs.push_back(mk(1,0,0, 0,0,1, 1,1, 5,1, 0));
        vecs.push_back(mk(1,0,0, 0,0,1, 0,1, 0,0, 5));
        vecs.push_back(mk(1,0,1,10,0,0, 0,1, 0,0, 5));
        vecs.push_back(mk(1,0,1,11,0,0, 1,1,10,0, 5));
        vecs.push_back(mk(1,0,1,12,0,0, 1,1,10,0, 5));
        vecs.push_back(mk(1,0,1,13,1,0, 1,1,10,0, 5));
        vecs.push_back(mk(1,0,1,14,0,0, 1,0,10,0, 5));
        vecs.push_back(mk(1,0,0, 0,0,1, 1,0,10,0, 5));
        vecs.push_back(mk(1,0,0, 0,0,1, 1,1,11,0,10));
        vecs.push_back(mk(1,0,0, 0,0,1, 1,1,12,0,11));
        vecs.push_back(mk(1,0,0, 0,0,1, 1,1,13,1,12));
        vecs.push_back(mk(1,0,0, 0,0,1, 0,1, 0,0,13));
        vecs.push_back(mk(1,0,1,20,0,0, 0,1, 0,0,13));
        vecs.push_back(mk(1,0,1,21,0,1, 1,1,20,0,13));
        vecs.push_back(mk(1,0,1,22,0,1, 1,1,21,0,20));
        vecs.push_back(mk(1,0,0, 0,0,1, 1,1,22,0,21));
        vecs.push_back(mk(1,0,0, 0,0,1, 0,1, 0,0,22));

        foreach (vecs[i]) begin
            apply(vecs[i].en, vecs[i].srst, vecs[i].iv, vecs[i].id,
                  vecs[i].last, vecs[i].ordy);
            @(negedge clk);
            check_outs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].er,
                       vecs[i].eid, vecs[i].elast, vecs[i].est);
            tick();
        end

        // Enable gating: state frozen while en = 0, same head afterwards.
        model_cycle("en_fill", 1'b1, 1'b0, 1'b1, 6'd30, 1'b0, 1'b0);
        model_cycle("en_fill", 1'b1, 1'b0, 1'b1, 6'd31, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++)
            model_cycle("en_off", 1'b0, 1'b0, 1'b1, ID_W'($urandom), 1'b0, 1'b1);
        model_cycle("en_on", 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        model_cycle("en_pop", 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        // sync_rst overrides en = 0 and a pending push.
        model_cycle("srst", 1'b0, 1'b1, 1'b1, 6'd40, 1'b0, 1'b1);
        model_cycle("after_srst", 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1);

        // Continuous streaming across three pointer wraps.
        for (int i = 0; i < 3 * DEPTH + 1; i++)
            model_cycle("wrap", 1'b1, 1'b0, 1'(i < 3 * DEPTH), ID_W'(i),
                        1'(i == 3 * DEPTH - 1), 1'b1);

        // Randomized traffic: gaps, stalls, enable drops, rare clears.
        for (int i = 0; i < 400; i++)
            model_cycle("rand", 1'($urandom_range(0, 9) != 0),
                        1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
                        ID_W'($urandom), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 2) != 0));

        // Asynchronous reset in the middle of traffic.
        model_cycle("pre_arst", 1'b1, 1'b0, 1'b1, 6'd50, 1'b1, 1'b0);
        apply(1'b1, 1'b0, 1'b1, 6'd51, 1'b0, 1'b0);
        #2 nrst = 1'b0;
        #1;
        m_q.delete();
        m_status = '0;
        model_check("arst");
        @(negedge clk);
        nrst = 1'b1;
        model_check("arst_rel");
        tick();
        model_cycle("post_arst", 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
